// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared FSM state encoding and counter-width helper
package serial_addsub_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/serial_addsub_if.sv
// serial_addsub_if: request/result bundle for the bit-serial adder/subtractor
// master drives start/sub/a/b; slave returns busy/done/sum/cout/ovf
interface serial_addsub_if #(parameter int WIDTH = 8);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  modport master (output start, sub, a, b, input busy, done, sum, cout, ovf);
  modport slave (input start, sub, a, b, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_addsub_shift_reg.sv
// serial_shift_reg: parallel-load, shift-right register with LSB serial out
// ports: clk, res (async active-high), i_load/i_din parallel load, i_shift shift enable, o_sout LSB
module serial_shift_reg #(parameter int WIDTH = 8) (
  input  logic             clk,
  input  logic             res,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_shift,
  output logic             o_sout
);
  logic [WIDTH-1:0] r_q;
  always_ff @(posedge clk or posedge res)
    if (res) r_q <= '0;
    else r_q <= i_load ? i_din : i_shift ? {1'b0, r_q[WIDTH-1:1]} : r_q;
  assign o_sout = r_q[0];
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: LSB-first bit-serial adder/subtractor with carry/overflow flags and done pulse
// ports: clk, res (async active-high), bus (serial_addsub_if.slave)
// optional: define SERIAL_ADDSUB_SAT_EN to saturate the result on signed overflow
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           res,
  serial_addsub_if.slave bus
);
  localparam int CW = clog2(WIDTH);
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-2:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;
  logic             w_load;
  logic             w_shift;
  logic             w_a0;
  logic             w_b0;
  logic             w_s;
  logic             w_c;
  logic             w_ovf;
  logic             w_last;
  logic [WIDTH-1:0] w_nxt;
  logic [WIDTH-1:0] w_sum;
  assign w_load  = (r_state == IDLE) && bus.start;
  assign w_shift = (r_state == SHIFT);
  serial_shift_reg #(.WIDTH(WIDTH)) u_a (
    .clk    (clk),
    .res    (res),
    .i_load (w_load),
    .i_din  (bus.a),
    .i_shift(w_shift),
    .o_sout (w_a0)
  );
  // subtraction is a + ~b + 1; the +1 enters through the initial carry
  serial_shift_reg #(.WIDTH(WIDTH)) u_b (
    .clk    (clk),
    .res    (res),
    .i_load (w_load),
    .i_din  (bus.sub ? ~bus.b : bus.b),
    .i_shift(w_shift),
    .o_sout (w_b0)
  );
  assign w_s    = w_a0 ^ w_b0 ^ r_carry;
  assign w_c    = (w_a0 & w_b0) | (r_carry & (w_a0 ^ w_b0));
  assign w_ovf  = r_carry ^ w_c;
  assign w_last = (r_cnt == CW'(WIDTH - 1));
  // r_res keeps the WIDTH-1 bits already produced; the new bit lands on top
  assign w_nxt  = {w_s, r_res};
`ifdef SERIAL_ADDSUB_SAT_EN
  // on overflow both effective operands share a sign; A's MSB is on the wire now
  assign w_sum = !w_ovf ? w_nxt :
                 w_a0 ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign w_sum = w_nxt;
`endif
  always_ff @(posedge clk or posedge res)
    if (res) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE:
          if (bus.start) begin
            r_state <= SHIFT;
            r_carry <= bus.sub;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        SHIFT: begin
          r_carry <= w_c;
          r_cnt   <= r_cnt + 1'b1;
          r_res   <= w_nxt[WIDTH-1:1];
          if (w_last) begin
            r_state <= DONE;
            r_sum   <= w_sum;
            r_cout  <= w_c;
            r_ovf   <= w_ovf;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised bit-serial adder/subtractor, LSB first, one full-adder cell plus carry flop.
- Operands are captured in parallel on a start handshake and processed one bit per clock.
- Produces a registered WIDTH-bit result with carry and signed-overflow flags, and a one-cycle done pulse.
- Generalises the fixed 8-bit serial adder: adds width, subtract mode, handshake, flags and a stable result register.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
- clk    input   1      clock, all state on rising edge
- res    input   1      reset, asynchronous, active-high; clears all state
- start  input   1      request; sampled only in IDLE
- sub    input   1      0 = a+b, 1 = a-b; sampled with start
- a      input   WIDTH  operand A; sampled with start
- b      input   WIDTH  operand B; sampled with start
- busy   output  1      high in SHIFT and DONE
- done   output  1      one-cycle pulse, high in DONE
- sum    output  WIDTH  last completed result; held stable during computation
- cout   output  1      final carry out (for sub: 1 = no borrow)
- ovf    output  1      signed overflow of last result

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE; sum=0, cout=0, ovf=0, busy=0, done=0; carry, counter and operand shift registers cleared.
- Operation aborted by reset is lost; no done pulse is issued.
- FSM states: IDLE, SHIFT, DONE.
- IDLE -> SHIFT on an edge with start=1 (call it edge 0):
  - load a into shift reg A and (sub ? ~b : b) into shift reg B;
  - carry := sub; counter := 0.
- SHIFT, one bit per edge (edges 1..WIDTH):
  - s = A0 ^ B0 ^ carry; c = A0&B0 | carry&(A0^B0);
  - s shifts into the MSB of the internal result register; A and B shift right;
  - carry := c; counter++.
- Final bit (counter==WIDTH-1), on that edge:
  - sum := {s, result[WIDTH-1:1]}; cout := c; ovf := carry_into_MSB ^ c;
  - state := DONE.
- DONE lasts exactly one cycle (done=1), then returns to IDLE.
- start is ignored while busy, including during DONE. Back-to-back operations: start asserted in the cycle after done.
- Latency: done and the new sum/cout/ovf are visible in the cycle after edge WIDTH. Throughput is one operation per WIDTH+2 cycles.
- sum/cout/ovf change only on a completion edge or on reset; between operations they hold.
- Arithmetic is modulo 2^WIDTH; signed interpretation is two's complement.
- Input values outside 0/1 (X/Z) need no special handling; behaviour is defined for known inputs only.

Optional Feature:
- Macro: SERIAL_ADDSUB_SAT_EN.
- Defined: on completion with signed overflow, sum := most-positive (0x7F..F) if the true MSB result would be positive (operand sign bit 0), else most-negative (0x80..0). ovf is still reported; cout is unchanged.
- Undefined: wrap-around result only; no saturation logic is present.

Decomposition:
- Package serial_addsub_pkg:
  - state enum/localparams IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
  - counter-width function clog2 (counter width = clog2(WIDTH)).
- Sub-module serial_shift_reg #(WIDTH):
  - ports: parallel load, shift-right enable, serial out (LSB), async active-high res;
  - instantiated twice, for A and B.
- The full-adder cell stays inline.

Test Plan:
- WIDTH=8, add 0x35+0x4A: done in the cycle after edge 8; sum=0x7F, cout=0, ovf=0; busy high for 9 cycles.
- add 0xFF+0x01 -> sum=0x00, cout=1, ovf=0. add 0x7F+0x01 -> sum=0x80, ovf=1; with SERIAL_ADDSUB_SAT_EN -> sum=0x7F, ovf=1.
- sub 0x10-0x20 -> sum=0xF0, cout=0, ovf=0. sub 0x80-0x01 -> sum=0x7F, ovf=1; with SAT -> sum=0x80.
- Pulse start with new operands on cycles 3 and 8 of an op: both ignored; the first result is correct; sum keeps its prior value until completion.
- Assert res asynchronously mid-SHIFT (between edges): outputs go to 0 immediately, no done pulse; a subsequent 0x01+0x01 yields 0x02.
- WIDTH=32, 0xFFFFFFFF+0x00000001 -> sum=0, cout=1; done in the cycle after edge 32; back-to-back start right after done is accepted.
